// File: rtl/rv_operand_pkg.sv
// Shared encodings for the operand forwarding stage: operand selects,
// forwarding source codes and the constant-four operand.
package rv_operand_pkg;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_EX   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;

    localparam logic [31:0] FOUR = 32'd4;

endpackage

// File: rtl/fwd_resolve.sv
// Per-operand bypass mux: picks EX, then MEM, then register-file data.
// Purely combinational; x0 is never forwarded.
module fwd_resolve
    import rv_operand_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rs_val_i,
    input  logic              ex_wen_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_val_i,
    input  logic              mem_wen_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_val_i,
    output logic [XLEN-1:0]   fwd_val_o,
    output logic [1:0]        fwd_src_o
);

    logic addr_nz;
    logic ex_hit;
    logic mem_hit;

    assign addr_nz = (rs_addr_i != '0);
    assign ex_hit  = (FWD_EN != 0) && ex_wen_i  && (ex_rd_i  == rs_addr_i) && addr_nz;
    assign mem_hit = (FWD_EN != 0) && mem_wen_i && (mem_rd_i == rs_addr_i) && addr_nz;

    // EX holds the younger result, so it outranks MEM.
    always_comb begin
        fwd_val_o = rs_val_i;
        fwd_src_o = FWD_NONE;
        if (ex_hit) begin
            fwd_val_o = ex_val_i;
            fwd_src_o = FWD_EX;
        end else if (mem_hit) begin
            fwd_val_o = mem_val_i;
            fwd_src_o = FWD_MEM;
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// Resolves bypassed operands and registers them in a single pipeline slot.
// 1-cycle latency; holds while out_ready is low, accepts on the draining edge.
module operand_fwd_stage
    import rv_operand_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   pc,
    input  logic [1:0]        a_sel,
    input  logic [1:0]        b_sel,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_val,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_val,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op_a,
    output logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   store_data,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [1:0]      rs1_src, rs2_src;
    logic [XLEN-1:0] a_mux, b_mux;
    logic            take;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d, st_q, st_d;
    logic [1:0]      fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_rs1 (
        .rs_addr_i (rs1_addr),
        .rs_val_i  (rs1_val),
        .ex_wen_i  (ex_wen),
        .ex_rd_i   (ex_rd),
        .ex_val_i  (ex_val),
        .mem_wen_i (mem_wen),
        .mem_rd_i  (mem_rd),
        .mem_val_i (mem_val),
        .fwd_val_o (rs1_fwd),
        .fwd_src_o (rs1_src)
    );

    fwd_resolve #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_rs2 (
        .rs_addr_i (rs2_addr),
        .rs_val_i  (rs2_val),
        .ex_wen_i  (ex_wen),
        .ex_rd_i   (ex_rd),
        .ex_val_i  (ex_val),
        .mem_wen_i (mem_wen),
        .mem_rd_i  (mem_rd),
        .mem_val_i (mem_val),
        .fwd_val_o (rs2_fwd),
        .fwd_src_o (rs2_src)
    );

    assign in_ready = !valid_q || out_ready;
    assign take     = in_valid && in_ready;

    always_comb begin
        a_mux = '0;
        case (a_sel)
            A_RS1:   a_mux = rs1_fwd;
            A_PC:    a_mux = pc;
            default: a_mux = '0;
        endcase
        b_mux = XLEN'(FOUR);
        case (b_sel)
            B_RS2:   b_mux = rs2_fwd;
            B_IMM:   b_mux = imm;
            default: b_mux = XLEN'(FOUR);
        endcase
    end

    // Flush wins over a same-cycle accept; the data it loads is never seen.
    always_comb begin
        valid_d = valid_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        st_d    = st_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (take) begin
            op_a_d  = a_mux;
            op_b_d  = b_mux;
            st_d    = rs2_fwd;
            fwd_a_d = rs1_src;
            fwd_b_d = rs2_src;
        end
        if (flush)          valid_d = 1'b0;
        else if (take)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            st_q    <= '0;
            fwd_a_q <= FWD_NONE;
            fwd_b_q <= FWD_NONE;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            st_q    <= st_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign out_valid  = valid_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign store_data = st_q;
    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Bench for operand_fwd_stage: directed vector table, stall/flush/reset
// sequences, then random traffic against a behavioural model.
module tb_operand_fwd_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0]  rs1_addr, rs2_addr, ex_rd, mem_rd;
    logic [31:0] rs1_val, rs2_val, imm, pc, ex_val, mem_val;
    logic [1:0]  a_sel, b_sel, fwd_a, fwd_b;
    logic        ex_wen, mem_wen;
    logic [31:0] op_a, op_b, store_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    operand_fwd_stage #(.XLEN(32), .REG_AW(5), .FWD_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm(imm), .pc(pc), .a_sel(a_sel), .b_sel(b_sel),
        .ex_wen(ex_wen), .ex_rd(ex_rd), .ex_val(ex_val),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_val(mem_val),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .store_data(store_data), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct {
        logic [1:0]  a_sel, b_sel;
        logic [4:0]  rs1_addr, rs2_addr, ex_rd, mem_rd;
        logic [31:0] rs1_val, rs2_val, imm, pc, ex_val, mem_val;
        logic        ex_wen, mem_wen;
        logic [31:0] e_a, e_b, e_st;
        logic [1:0]  e_fa, e_fb;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [1:0] as, bs, input logic [4:0] r1a,
                                input logic [31:0] r1v, input logic [4:0] r2a,
                                input logic [31:0] r2v, im, p, input logic xw,
                                input logic [4:0] xr, input logic [31:0] xv,
                                input logic mw, input logic [4:0] mr, input logic [31:0] mv,
                                input logic [31:0] ea, eb, est, input logic [1:0] efa, efb);
        vec_t v;
        v.a_sel = as; v.b_sel = bs; v.rs1_addr = r1a; v.rs1_val = r1v;
        v.rs2_addr = r2a; v.rs2_val = r2v; v.imm = im; v.pc = p;
        v.ex_wen = xw; v.ex_rd = xr; v.ex_val = xv;
        v.mem_wen = mw; v.mem_rd = mr; v.mem_val = mv;
        v.e_a = ea; v.e_b = eb; v.e_st = est; v.e_fa = efa; v.e_fb = efb;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {27'd0, out_valid, op_a, op_b, store_data, fwd_a, fwd_b};
    endfunction

    function automatic logic [127:0] expv(input vec_t v);
        return {27'd0, 1'b1, v.e_a, v.e_b, v.e_st, v.e_fa, v.e_fb};
    endfunction

    task automatic drive(input vec_t v);
        a_sel = v.a_sel; b_sel = v.b_sel;
        rs1_addr = v.rs1_addr; rs1_val = v.rs1_val;
        rs2_addr = v.rs2_addr; rs2_val = v.rs2_val;
        imm = v.imm; pc = v.pc;
        ex_wen = v.ex_wen; ex_rd = v.ex_rd; ex_val = v.ex_val;
        mem_wen = v.mem_wen; mem_rd = v.mem_rd; mem_val = v.mem_val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: which stage supplies a source register, written from the bypass rules.
    function automatic logic [33:0] source_of(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return {2'd0, rf};
        if (ex_wen && ex_rd == a) return {2'd1, ex_val};
        if (mem_wen && mem_rd == a) return {2'd2, mem_val};
        return {2'd0, rf};
    endfunction

    function automatic logic [127:0] model_bundle();
        logic [33:0] s1, s2;
        logic [31:0] a, b;
        s1 = source_of(rs1_addr, rs1_val);
        s2 = source_of(rs2_addr, rs2_val);
        a = (a_sel == 2'd0) ? s1[31:0] : (a_sel == 2'd1) ? pc : 32'd0;
        b = (b_sel == 2'd0) ? s2[31:0] : (b_sel == 2'd1) ? imm : 32'd4;
        return {27'd0, 1'b1, a, b, s2[31:0], s1[33:32], s2[33:32]};
    endfunction

    initial begin
        logic        m_v;
        logic [127:0] m_b;

        vecs[0] = mk(0, 0, 5, 32'h11, 6, 32'h22, 0, 0, 1, 5, 32'hAAAA_0001, 1, 5, 32'hBBBB_0002,
                     32'hAAAA_0001, 32'h22, 32'h22, 1, 0);
        vecs[1] = mk(0, 0, 3, 32'h33, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'h1234,
                     32'h33, 0, 0, 0, 0);
        vecs[2] = mk(1, 2, 1, 32'h10, 7, 32'h70, 0, 32'h100, 0, 7, 32'h99, 1, 7, 32'h55,
                     32'h100, 4, 32'h55, 0, 2);
        vecs[3] = mk(2, 1, 9, 32'h90, 9, 32'h91, 32'hFFFF_FFF0, 32'h200, 1, 9, 32'h77, 0, 0, 0,
                     0, 32'hFFFF_FFF0, 32'h77, 1, 1);
        vecs[4] = mk(3, 3, 4, 32'h44, 8, 32'h88, 5, 32'h300, 0, 4, 1, 0, 8, 2,
                     0, 4, 32'h88, 0, 0);
        vecs[5] = mk(0, 0, 12, 32'h120, 13, 32'h130, 0, 0, 1, 12, 32'hDEAD_0000, 1, 13, 32'hBEEF,
                     32'hDEAD_0000, 32'hBEEF, 32'hBEEF, 1, 2);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        drive(vecs[0]);

        // Reset held for two edges, then released.
        tick();
        check("reset_in_ready", in_ready, 1);
        tick();
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        tick();
        check("post_reset_outs", outs(), 0);
        check("post_reset_in_ready", in_ready, 1);

        // Directed vectors back to back: each lands one edge later, no bubbles.
        in_valid = 1'b1; out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_in_ready", i), in_ready, 1);
            tick();
            check($sformatf("vec%0d_outs", i), outs(), expv(vecs[i]));
        end

        // Stall three cycles with a new bundle and changed EX/MEM waiting.
        drive(vecs[0]);
        tick();
        out_ready = 1'b0;
        drive(vecs[1]);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), in_ready, 0);
            tick();
            check($sformatf("stall%0d_hold", c), outs(), expv(vecs[0]));
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        check("release_no_bubble", outs(), expv(vecs[1]));
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);

        // Flush during a stall discards both held and offered bundles.
        in_valid = 1'b1;
        drive(vecs[2]);
        tick();
        out_ready = 1'b0;
        drive(vecs[3]);
        tick();
        check("flush_pre_hold", outs(), expv(vecs[2]));
        flush = 1'b1;
        tick();
        check("flush_valid", out_valid, 0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("flush_no_stale%0d", c), out_valid, 0);
        end

        // Reset beats flush and transfer-in mid-stall.
        in_valid = 1'b1;
        drive(vecs[4]);
        tick();
        out_ready = 1'b0; flush = 1'b1; rst = 1'b1;
        tick();
        check("reset_mid_stall", outs(), 0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        check("reset_mid_stall_ready", in_ready, 1);
        check("reset_mid_stall_valid", out_valid, 0);

        // Random traffic against the model.
        m_v = 1'b0;
        m_b = '0;
        for (int n = 0; n < 400; n++) begin
            rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));    mem_rd = 5'($urandom_range(0, 3));
            ex_wen = 1'($urandom);  mem_wen = 1'($urandom);
            rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; pc = $urandom;
            ex_val = $urandom; mem_val = $urandom;
            a_sel = 2'($urandom); b_sel = 2'($urandom);
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            check("rand_in_ready", in_ready, {127'd0, (!m_v || out_ready)});
            if (flush) begin
                m_v = 1'b0;
            end else if (in_valid && (!m_v || out_ready)) begin
                m_v = 1'b1;
                m_b = model_bundle();
            end else if (out_ready) begin
                m_v = 1'b0;
            end
            tick();
            check("rand_out_valid", out_valid, {127'd0, m_v});
            if (m_v) check("rand_bundle", outs(), m_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fwd_stage.md
OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width in bits.
REQ-002 SHALL have parameter REG_AW, default 5: register-address width in bits.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 enables forwarding; 0 makes both forwarding comparators constant-miss.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream operand bundle valid.
REQ-007 in_ready  out  1  stage can accept a bundle this cycle.
REQ-008 rs1_addr, rs2_addr  in  REG_AW  source register indices.
REQ-009 rs1_val, rs2_val  in  XLEN  register-file read data.
REQ-010 imm  in  XLEN  sign-extended immediate.
REQ-011 pc  in  XLEN  instruction address.
REQ-012 a_sel  in  2  operand-A select: RS1=0, PC=1, ZERO=2 (3 reserved, treated as ZERO).
REQ-013 b_sel  in  2  operand-B select: RS2=0, IMM=1, FOUR=2 (3 reserved, treated as FOUR).
REQ-014 ex_wen, ex_rd, ex_val  in  1/REG_AW/XLEN  EX-stage writeback candidate.
REQ-015 mem_wen, mem_rd, mem_val  in  1/REG_AW/XLEN  MEM-stage writeback candidate.
REQ-016 flush  in  1  discard the held bundle and the bundle presented this cycle.
REQ-017 out_valid  out  1  registered bundle valid.
REQ-018 out_ready  in  1  downstream accepts the bundle.
REQ-019 op_a, op_b, store_data  out  XLEN  registered operands; store_data is the forwarded rs2 value regardless of b_sel.
REQ-020 fwd_a, fwd_b  out  2  registered forwarding source per operand: 0=none, 1=EX, 2=MEM.

Function
REQ-021 Forwarding for rsN SHALL select ex_val when ex_wen=1, ex_rd==rsN_addr and rsN_addr!=0; otherwise mem_val under the same rule for MEM; otherwise rsN_val.
REQ-022 When EX and MEM both match, EX SHALL win.
REQ-023 rsN_addr==0 SHALL yield rsN_val unmodified and fwd code 0, even if ex_rd or mem_rd is 0 with wen=1.
REQ-024 op_a SHALL be the forwarded rs1, pc or 0 per a_sel; op_b SHALL be the forwarded rs2, imm or 32'd4 (zero-extended to XLEN) per b_sel.
REQ-025 in_ready SHALL equal (!out_valid || out_ready) combinationally, with no dependence on in_valid.
REQ-026 Transfer-in SHALL occur when in_valid && in_ready; the output registers SHALL then load on that edge, giving one cycle of latency.
REQ-027 When out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-028 When out_ready=1 and no transfer-in occurs, out_valid SHALL clear on the next edge.
REQ-029 Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1) SHALL load the new bundle with no bubble.
REQ-030 flush=1 SHALL clear out_valid on the next edge, overriding any transfer-in that cycle; data registers are don't-care.
REQ-031 Forwarding values SHALL be sampled only at transfer-in; a later EX/MEM change SHALL NOT alter held outputs.

Reset
REQ-032 On a rising edge with rst=1, out_valid, op_a, op_b, store_data, fwd_a and fwd_b SHALL all be 0.
REQ-033 rst SHALL take priority over flush and transfer-in, including mid-stall.
REQ-034 in_ready SHALL be 1 during and after reset, because it follows from out_valid=0.

Structure
REQ-035 Package rv_operand_pkg SHALL hold the a_sel/b_sel encodings, the fwd code constants and the FOUR constant.
REQ-036 A sub-module fwd_resolve SHALL implement REQ-021..023 combinationally for one operand and SHALL be instantiated twice.
REQ-037 The block SHALL contain one pipeline register set and no other state.

Verification
REQ-038 Reset: rst=1 for 2 cycles, then release -> out_valid=0, all outputs 0, in_ready=1.
REQ-039 Precedence: rs1_addr=5, ex_rd=5 with ex_val=0xAAAA_0001, mem_rd=5 with mem_val=0xBBBB_0002, a_sel=RS1 -> op_a=0xAAAA_0001 and fwd_a=1 one cycle later.
REQ-040 x0 guard: rs2_addr=0, rs2_val=0, ex_rd=0, ex_wen=1, ex_val=0xFFFF_FFFF, b_sel=RS2 -> op_b=0, fwd_b=0.
REQ-041 Select paths: a_sel=PC, pc=0x100, b_sel=FOUR, rs2 forwarded from MEM with value 0x55 -> op_a=0x100, op_b=4, store_data=0x55, fwd_b=2.
REQ-042 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; then out_ready=1 -> next bundle loads on that edge with no bubble.
REQ-043 Flush: flush=1 during a stall with in_valid=1 -> out_valid=0 on the next edge and no stale bundle is emitted afterward.
